bullet_hit_scanner: RTL

Read-side consumer of the bullet table on its collision/damage port. Once per game frame it walks the eight bullet slots by driving the table index, tests each rendered bullet's box against the player heart's box, and classifies hits by bullet colour. It then applies the net damage or heal to a saturating HP register, with post-hit invulnerability. It sits between the bullet table and the game controller and HUD.

---
 rtl/bullet_hit_scanner_if.sv | 40 ++++
 rtl/bullet_hit_scanner.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/bullet_hit_scanner_if.sv
// bullet_hit_scanner_if
//   Bundles the signals between the hit scanner, the game controller and the
//   bullet table's collision/damage read port.
//   master : controller/table side (drives start, player state, table data)
//   slave  : scanner side (drives bullet_index and the scan results)
//   Signals:
//     start, player_pos[15:0], player_size[15:0], player_moving  -> scanner
//     bullet_index[2:0]                                          -> table
//     bullet_pos[15:0], bullet_size[15:0], bullet_color[2:0],
//     bullet_render                                              -> scanner
//     busy, done, hit, hit_mask[7:0], hp[7:0], dead              -> controller/HUD
interface bullet_hit_scanner_if;
  logic        start;
  logic [15:0] player_pos;
  logic [15:0] player_size;
  logic        player_moving;
  logic [2:0]  bullet_index;
  logic [15:0] bullet_pos;
  logic [15:0] bullet_size;
  logic [2:0]  bullet_color;
  logic        bullet_render;
  logic        busy;
  logic        done;
  logic        hit;
  logic [7:0]  hit_mask;
  logic [7:0]  hp;
  logic        dead;

  modport master (
    output start, player_pos, player_size, player_moving,
    output bullet_pos, bullet_size, bullet_color, bullet_render,
    input  bullet_index, busy, done, hit, hit_mask, hp, dead
  );

  modport slave (
    input  start, player_pos, player_size, player_moving,
    input  bullet_pos, bullet_size, bullet_color, bullet_render,
    output bullet_index, busy, done, hit, hit_mask, hp, dead
  );
endinterface

// File: rtl/bullet_hit_scanner.sv
// bullet_hit_scanner
//   Once per frame (start pulse) walks the eight bullet-table slots, tests each
//   rendered bullet box against the latched heart box, accumulates damage/heal
//   by colour and applies the net result to a saturating HP register with
//   post-hit invulnerability. Fixed 10-cycle latency from start to done.
//   Ports:
//     clk    : system clock
//     reset  : synchronous, active-high
//     bus    : bullet_hit_scanner_if.slave (start/player in, table index out,
//              table data in, busy/done/hit/hit_mask/hp/dead out)
module bullet_hit_scanner #(
  parameter int MAX_HP       = 20,
  parameter int DMG_WHITE    = 1,
  parameter int DMG_BLUE     = 1,
  parameter int HEAL_GREEN   = 1,
  parameter int INVULN_SCANS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  bullet_hit_scanner_if.slave   bus
);

  localparam logic [2:0] COL_WHITE = 3'b000;
  localparam logic [2:0] COL_GREEN = 3'b001;
  localparam logic [2:0] COL_BLUE  = 3'b010;

  localparam logic [7:0]        DMG_WHITE_8  = 8'(DMG_WHITE);
  localparam logic [7:0]        DMG_BLUE_8   = 8'(DMG_BLUE);
  localparam logic [7:0]        HEAL_GREEN_8 = 8'(HEAL_GREEN);
  localparam logic [7:0]        MAX_HP_8     = 8'(MAX_HP);
  localparam logic signed [9:0] MAX_HP_S     = 10'(MAX_HP);
  localparam logic [3:0]        INVULN_4     = 4'(INVULN_SCANS);

  typedef enum logic [1:0] {IDLE, SCAN, APPLY, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q;
  logic [7:0]  hp_q;
  logic [3:0]  inv_q;
  logic [7:0]  hit_mask_q;
  logic        hit_q;

  // Per-scan data: cleared on accepted start, so no reset needed.
  logic [7:0]  px_q, py_q, pw_q, ph_q;
  logic        pmov_q;
  logic [7:0]  dmg_q, heal_q, mask_acc_q;

  logic [7:0]  bx, by, bw, bh;
  logic [8:0]  p_right, p_bottom, b_right, b_bottom;
  logic        overlap, slot_hit, dead_w, accept;
  logic [7:0]  eff_dmg;
  logic signed [9:0] hp_sum;

  function automatic logic [7:0] sat_hp(input logic signed [9:0] v);
    if (v < 10'sd0)
      return 8'd0;
    else if (v > MAX_HP_S)
      return MAX_HP_8;
    else
      return v[7:0];
  endfunction

  assign bx = bus.bullet_pos[15:8];
  assign by = bus.bullet_pos[7:0];
  assign bw = bus.bullet_size[15:8];
  assign bh = bus.bullet_size[7:0];

  // 9-bit edges so x+w / y+h never wrap past 255.
  assign p_right  = {1'b0, px_q} + {1'b0, pw_q};
  assign p_bottom = {1'b0, py_q} + {1'b0, ph_q};
  assign b_right  = {1'b0, bx} + {1'b0, bw};
  assign b_bottom = {1'b0, by} + {1'b0, bh};

  // Strict inequalities: boxes that merely touch do not collide.
  assign overlap  = ({1'b0, bx} < p_right) && ({1'b0, px_q} < b_right) &&
                    ({1'b0, by} < p_bottom) && ({1'b0, py_q} < b_bottom);
  assign slot_hit = bus.bullet_render && (bw != 8'd0) && (bh != 8'd0) && overlap;

  assign dead_w  = (hp_q == 8'd0);
  assign accept  = (state_q == IDLE) && bus.start && !dead_w;
  assign eff_dmg = (inv_q != 4'd0) ? 8'd0 : dmg_q;
  assign hp_sum  = $signed({2'b00, hp_q}) - $signed({2'b00, eff_dmg})
                 + $signed({2'b00, heal_q});

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SCAN;
      SCAN:    if (idx_q == 3'd7) state_d = APPLY;
      APPLY:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      hp_q       <= MAX_HP_8;
      inv_q      <= 4'd0;
      hit_mask_q <= 8'd0;
      hit_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE:  idx_q <= 3'd0;
        // Incrementing past 7 wraps to 0, leaving the index parked for IDLE.
        SCAN:  idx_q <= idx_q + 3'd1;
        APPLY: begin
          hp_q       <= sat_hp(hp_sum);
          hit_mask_q <= mask_acc_q;
          hit_q      <= (eff_dmg != 8'd0);
          if (eff_dmg != 8'd0)
            inv_q <= INVULN_4;
          else if (inv_q != 4'd0)
            inv_q <= inv_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      px_q       <= bus.player_pos[15:8];
      py_q       <= bus.player_pos[7:0];
      pw_q       <= bus.player_size[15:8];
      ph_q       <= bus.player_size[7:0];
      pmov_q     <= bus.player_moving;
      dmg_q      <= 8'd0;
      heal_q     <= 8'd0;
      mask_acc_q <= 8'd0;
    end else if ((state_q == SCAN) && slot_hit) begin
      mask_acc_q[idx_q] <= 1'b1;
      case (bus.bullet_color)
        COL_WHITE: dmg_q  <= dmg_q + DMG_WHITE_8;
        COL_BLUE:  if (pmov_q) dmg_q <= dmg_q + DMG_BLUE_8;
        COL_GREEN: heal_q <= heal_q + HEAL_GREEN_8;
        default:   ;
      endcase
    end
  end

  assign bus.bullet_index = idx_q;
  assign bus.busy         = (state_q == SCAN) || (state_q == APPLY);
  assign bus.done         = (state_q == DONE);
  assign bus.hit          = (state_q == DONE) && hit_q;
  assign bus.hit_mask     = hit_mask_q;
  assign bus.hp           = hp_q;
  assign bus.dead         = dead_w;

endmodule
